platform_sprite_fetch: RTL and testbench

//  Read-side client of the platform sprite ROM. Maps the VGA pixel stream to ROM read addresses for one platform.

---
 rtl/platform_sprite_fetch_if.sv | 37 +++
 rtl/platform_sprite_fetch.sv | 145 ++++++++++++++
 tb/tb_platform_sprite_fetch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/platform_sprite_fetch_if.sv
// Pixel-stream / ROM-read bundle for the platform sprite fetcher.
// slave: the fetcher. master: VGA counter + platform ROM + compositor side.
// PLAT_HFLIP_EN adds the hflip control bit.
interface platform_sprite_fetch_if;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [9:0]  plat_x;
  logic [9:0]  plat_y;
  logic [7:0]  platform_size;
`ifdef PLAT_HFLIP_EN
  logic        hflip;
`endif
  logic [18:0] rom_addr;
  logic [1:0]  anim_frame;
  logic [3:0]  rom_data;
  logic        pix_out_valid;
  logic [3:0]  pix_color;
  logic        pix_hit;

  modport slave (
    input  frame_start, pix_valid, pix_x, pix_y, plat_x, plat_y, platform_size, rom_data,
`ifdef PLAT_HFLIP_EN
    input  hflip,
`endif
    output rom_addr, anim_frame, pix_out_valid, pix_color, pix_hit
  );

  modport master (
    output frame_start, pix_valid, pix_x, pix_y, plat_x, plat_y, platform_size, rom_data,
`ifdef PLAT_HFLIP_EN
    output hflip,
`endif
    input  rom_addr, anim_frame, pix_out_valid, pix_color, pix_hit
  );
endinterface

// File: rtl/platform_sprite_fetch.sv
// Platform sprite ROM read client: pixel stream -> ROM address, ROM data ->
// registered colour/hit, plus per-video-frame animation bank select.
// Optional macro PLAT_HFLIP_EN: horizontal mirroring via shadowed hflip.
module platform_sprite_fetch #(
  parameter int         ROM_LAT         = 1,
  parameter int         FRAMES_PER_STEP = 15,
  parameter logic [3:0] TRANSP_IDX      = 4'h0,
  parameter int         SPR_H           = 32
) (
  input logic clk,
  input logic rst_n,
  platform_sprite_fetch_if.slave bus
);
  typedef enum logic {IDLE_CNT, STEP} anim_st_e;

  localparam logic [7:0] FCNT_LAST = 8'(FRAMES_PER_STEP - 1);
  // With one frame per step every pulse advances, so start in STEP.
  localparam anim_st_e   ST_INIT   = (FRAMES_PER_STEP == 1) ? STEP : IDLE_CNT;

  // Shadow copies of the placement, frozen for a whole video frame.
  logic [9:0] sx, sy;
  logic [7:0] ssize;
`ifdef PLAT_HFLIP_EN
  logic       sflip;
`endif

  // Shadow regs load at frame_start; the coinciding pixel still sees old values.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sx    <= '0;
      sy    <= '0;
      ssize <= '0;
`ifdef PLAT_HFLIP_EN
      sflip <= 1'b0;
`endif
    end else if (bus.frame_start) begin
      sx    <= bus.plat_x;
      sy    <= bus.plat_y;
      ssize <= bus.platform_size;
`ifdef PLAT_HFLIP_EN
      sflip <= bus.hflip;
`endif
    end

  logic        size_ok;
  logic [10:0] col, row, col_m, wid;
  logic        in_box;
  logic [18:0] addr_c;

  assign size_ok = (ssize == 8'd16) || (ssize == 8'd32) || (ssize == 8'd64) || (ssize == 8'd128);

  // Box test in 11-bit two's complement: bit 10 set means left of / above the sprite,
  // so off-screen overhang is clipped rather than wrapped.
  always_comb begin
    col    = {1'b0, bus.pix_x} - {1'b0, sx};
    row    = {1'b0, bus.pix_y} - {1'b0, sy};
    wid    = {3'b000, ssize};
    in_box = bus.pix_valid && size_ok && !col[10] && (col < wid) &&
             !row[10] && (row < 11'(SPR_H));
    col_m  = col;
`ifdef PLAT_HFLIP_EN
    if (sflip) col_m = wid - 11'd1 - col;
`endif
    addr_c = '0;
    if (in_box) addr_c = 19'(row) * 19'(wid) + 19'(col_m);
  end

  // vld_pipe[0]/hit_pipe[0] are the S0 stage; bit ROM_LAT lines up with rom_data.
  logic [ROM_LAT:0] vld_pipe, hit_pipe;
  logic [18:0]      rom_addr_q;

  // S0 register and ROM-latency shift register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe   <= '0;
      hit_pipe   <= '0;
      rom_addr_q <= '0;
    end else begin
      vld_pipe   <= (ROM_LAT+1)'({vld_pipe, bus.pix_valid});
      hit_pipe   <= (ROM_LAT+1)'({hit_pipe, in_box});
      rom_addr_q <= addr_c;
    end

  logic       ov_q, hit_q;
  logic [3:0] color_q;
  logic       opaque;

  assign opaque = hit_pipe[ROM_LAT] && (bus.rom_data != TRANSP_IDX);

  // Output stage: merge the delayed in-box flag with returned ROM data.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ov_q    <= 1'b0;
      hit_q   <= 1'b0;
      color_q <= '0;
    end else begin
      ov_q    <= vld_pipe[ROM_LAT];
      hit_q   <= opaque;
      color_q <= opaque ? bus.rom_data : 4'h0;
    end

  // Animation: STEP means the next frame_start completes a step.
  anim_st_e   st, st_nxt;
  logic [7:0] fcnt, fcnt_nxt;
  logic [1:0] anim, anim_nxt;

  // Animation state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st   <= ST_INIT;
      fcnt <= '0;
      anim <= '0;
    end else begin
      st   <= st_nxt;
      fcnt <= fcnt_nxt;
      anim <= anim_nxt;
    end

  // Animation next state: only frame_start moves it, so the bank never changes mid-frame.
  always_comb begin
    st_nxt   = st;
    fcnt_nxt = fcnt;
    anim_nxt = anim;
    if (bus.frame_start) begin
      case (st)
        IDLE_CNT: begin
          fcnt_nxt = fcnt + 8'd1;
          if (fcnt_nxt == FCNT_LAST) st_nxt = STEP;
        end
        STEP: begin
          fcnt_nxt = '0;
          anim_nxt = anim + 2'd1;
          st_nxt   = ST_INIT;
        end
        default: st_nxt = ST_INIT;
      endcase
    end
  end

  assign bus.rom_addr      = rom_addr_q;
  assign bus.anim_frame    = anim;
  assign bus.pix_out_valid = ov_q;
  assign bus.pix_hit       = hit_q;
  assign bus.pix_color     = color_q;
endmodule

// File: tb/tb_platform_sprite_fetch.sv
// Bench for platform_sprite_fetch: directed vectors, a per-cycle behavioural
// model with compare process, and literal expectations for the key cases.
module tb_platform_sprite_fetch;
  localparam int ROM_LAT = 1;
  localparam int FPS     = 2;
  localparam int RS      = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  platform_sprite_fetch_if bus();

  platform_sprite_fetch #(
    .ROM_LAT(ROM_LAT), .FRAMES_PER_STEP(FPS), .TRANSP_IDX(4'h0), .SPR_H(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ROM contents: address 5 is transparent, everything else opaque 1..15.
  function automatic logic [3:0] rom_fn(input logic [18:0] a);
    if (a == 19'd5) return 4'h0;
    return 4'((a % 15) + 1);
  endfunction

  // Registered ROM, one cycle of latency.
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  // Model: expected values per cycle slot, written when the pixel is sampled.
  logic [18:0] m_addr [RS];
  logic        m_ov   [RS];
  logic        m_hit  [RS];
  logic [3:0]  m_col  [RS];
  int          cyc = 0;
  int          pulses;
  logic [1:0]  m_anim;
  int          m_sx, m_sy, m_sz;
  bit          m_flip;

  always @(posedge clk) begin : model
    int col, row, w, sn, so;
    bit inb;
    logic [18:0] a;
    logic [3:0]  d;
    cyc = cyc + 1;
    sn  = cyc % RS;
    so  = (cyc + ROM_LAT + 1) % RS;
    if (!rst_n) begin
      for (int i = 0; i < RS; i++) begin
        m_addr[i] = '0; m_ov[i] = 1'b0; m_hit[i] = 1'b0; m_col[i] = '0;
      end
      pulses = 0; m_anim = 2'd0;
      m_sx = 0; m_sy = 0; m_sz = 0; m_flip = 1'b0;
    end else begin
      w   = m_sz;
      col = int'(bus.pix_x) - m_sx;
      row = int'(bus.pix_y) - m_sy;
      inb = bus.pix_valid && (w == 16 || w == 32 || w == 64 || w == 128) &&
            col >= 0 && col < w && row >= 0 && row < 32;
      if (m_flip) col = w - 1 - col;
      a = inb ? 19'(row * w + col) : 19'd0;
      d = rom_fn(a);
      m_addr[sn] = a;
      m_ov[so]   = bus.pix_valid;
      m_hit[so]  = inb && (d != 4'h0);
      m_col[so]  = (inb && d != 4'h0) ? d : 4'h0;
      if (bus.frame_start) begin
        pulses = pulses + 1;
        m_anim = 2'((pulses / FPS) % 4);
        m_sx = int'(bus.plat_x);
        m_sy = int'(bus.plat_y);
        m_sz = int'(bus.platform_size);
`ifdef PLAT_HFLIP_EN
        m_flip = bus.hflip;
`endif
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    int s;
    s = cyc % RS;
    if (!rst_n) begin
      chk("rst_addr", int'(bus.rom_addr), 0);
      chk("rst_anim", int'(bus.anim_frame), 0);
      chk("rst_ov",   int'(bus.pix_out_valid), 0);
      chk("rst_hit",  int'(bus.pix_hit), 0);
      chk("rst_col",  int'(bus.pix_color), 0);
    end else begin
      chk("addr",  int'(bus.rom_addr), int'(m_addr[s]));
      chk("anim",  int'(bus.anim_frame), int'(m_anim));
      chk("ov",    int'(bus.pix_out_valid), int'(m_ov[s]));
      chk("hit",   int'(bus.pix_hit), int'(m_hit[s]));
      chk("color", int'(bus.pix_color), int'(m_col[s]));
    end
  end

  task automatic pix(input int x, input int y);
    @(negedge clk);
    bus.pix_valid = 1'b1; bus.pix_x = 10'(x); bus.pix_y = 10'(y); bus.frame_start = 1'b0;
    @(negedge clk);
    bus.pix_valid = 1'b0;
  endtask

  task automatic fstart();
    @(negedge clk); bus.frame_start = 1'b1;
    @(negedge clk); bus.frame_start = 1'b0;
  endtask

  task automatic wait_out();
    repeat (ROM_LAT + 1) @(negedge clk);
  endtask

  task automatic place(input int x, input int y, input int sz);
    bus.plat_x = 10'(x); bus.plat_y = 10'(y); bus.platform_size = 8'(sz);
  endtask

  initial begin
    bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
    bus.pix_x = '0; bus.pix_y = '0;
`ifdef PLAT_HFLIP_EN
    bus.hflip = 1'b0;
`endif
    place(100, 200, 32);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ov",   int'(bus.pix_out_valid), 0);
    chk("reset_addr", int'(bus.rom_addr), 0);
    chk("reset_anim", int'(bus.anim_frame), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Animation: value seen before each of 9 pulses.
    for (int k = 0; k < 9; k++) begin
      chk("anim_seq", int'(bus.anim_frame), (k / 2) % 4);
      fstart();
      @(negedge clk);
    end

    // Top-left pixel.
    pix(100, 200);
    chk("t1_addr", int'(bus.rom_addr), 0);
    wait_out();
    chk("t1_ov",    int'(bus.pix_out_valid), 1);
    chk("t1_color", int'(bus.pix_color), 1);
    chk("t1_hit",   int'(bus.pix_hit), 1);

    // Bottom-right corner and one past it.
    pix(131, 231);
    chk("t2_addr", int'(bus.rom_addr), 1023);
    wait_out();
    chk("t2_color", int'(bus.pix_color), 4);
    pix(132, 231);
    chk("t2_out_addr", int'(bus.rom_addr), 0);
    wait_out();
    chk("t2_out_hit", int'(bus.pix_hit), 0);

    // Transparent ROM entry.
    pix(105, 200);
    chk("t3_addr", int'(bus.rom_addr), 5);
    wait_out();
    chk("t3_ov",    int'(bus.pix_out_valid), 1);
    chk("t3_hit",   int'(bus.pix_hit), 0);
    chk("t3_color", int'(bus.pix_color), 0);

    // frame_start with a pixel: pixel uses the old placement.
    @(negedge clk);
    place(0, 200, 32);
    bus.frame_start = 1'b1; bus.pix_valid = 1'b1; bus.pix_x = 10'd110; bus.pix_y = 10'd200;
    @(negedge clk);
    chk("fs_pix_old", int'(bus.rom_addr), 10);
    bus.frame_start = 1'b0; bus.pix_x = 10'd3; bus.pix_y = 10'd201;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    chk("fs_pix_new", int'(bus.rom_addr), 35);
    place(100, 200, 32);
    fstart();

    // Streaming line across the box edges, one pixel per clock.
    for (int x = 90; x < 176; x++) begin
      @(negedge clk);
      bus.pix_valid = ((x % 7) != 3); bus.pix_x = 10'(x); bus.pix_y = 10'd231;
    end
    @(negedge clk); bus.pix_valid = 1'b0;

    // Right-edge clipping, no wrap to the left side.
    place(620, 200, 32);
    fstart();
    for (int x = 612; x < 640; x++) begin
      @(negedge clk);
      bus.pix_valid = 1'b1; bus.pix_x = 10'(x); bus.pix_y = 10'd205;
    end
    @(negedge clk); bus.pix_valid = 1'b0;
    pix(639, 200);
    chk("clip_edge_addr", int'(bus.rom_addr), 19);
    pix(5, 200);
    chk("nowrap_addr", int'(bus.rom_addr), 0);
    wait_out();
    chk("nowrap_hit", int'(bus.pix_hit), 0);

    // Unsupported size blanks the frame.
    place(100, 200, 48);
    fstart();
    pix(100, 200);
    chk("s48_addr", int'(bus.rom_addr), 0);
    wait_out();
    chk("s48_ov",  int'(bus.pix_out_valid), 1);
    chk("s48_hit", int'(bus.pix_hit), 0);

    // Size change mid-frame is ignored until the next frame_start.
    place(100, 200, 32);
    fstart();
    bus.platform_size = 8'd48;
    pix(131, 231);
    chk("mid_48_addr", int'(bus.rom_addr), 1023);
    bus.platform_size = 8'd64;
    pix(131, 231);
    chk("mid_64_addr", int'(bus.rom_addr), 1023);
    wait_out();
    chk("mid_64_hit", int'(bus.pix_hit), 1);
    fstart();
    pix(131, 231);
    chk("s64_addr", int'(bus.rom_addr), 31 * 64 + 31);
    place(100, 200, 32);
    fstart();

    // Reset with three pixels in flight.
    @(negedge clk); bus.pix_valid = 1'b1; bus.pix_x = 10'd100; bus.pix_y = 10'd200;
    @(negedge clk); bus.pix_x = 10'd101;
    @(negedge clk); bus.pix_x = 10'd102;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ov",   int'(bus.pix_out_valid), 0);
    chk("async_addr", int'(bus.rom_addr), 0);
    chk("async_hit",  int'(bus.pix_hit), 0);
    chk("async_col",  int'(bus.pix_color), 0);
    chk("async_anim", int'(bus.anim_frame), 0);
    @(negedge clk); bus.pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_ov", int'(bus.pix_out_valid), 0);
    end

`ifdef PLAT_HFLIP_EN
    place(100, 200, 16);
    bus.hflip = 1'b1;
    fstart();
    pix(100, 200);
    chk("hflip_addr", int'(bus.rom_addr), 15);
    pix(115, 201);
    chk("hflip_addr2", int'(bus.rom_addr), 16);
    bus.hflip = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
